// File: rtl/pipeline_if_fetch_stage.sv
// rtl/pipeline_if_fetch_stage.sv - IF stage: sequential fetch over req/ack imem, fetch FIFO, registered IF->ID outputs
// Optional define IF_PERF_CNT_EN adds perf_fetch_cnt/perf_bubble_cnt outputs.
module pipeline_if_fetch_stage #(
  parameter logic [63:0] RESET_PC  = 64'h0,
  parameter logic [31:0] NOP_INST  = 32'h0000_0013,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_ID,
  input  logic        redirect_en,
  input  logic [63:0] redirect_pc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_IF,
  output logic [63:0] pc_IF,
  output logic        valid_IF
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_bubble_cnt
`endif
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DISCARD} state_t;

  state_t        state, state_n;
  logic [63:0]   fetch_pc, fetch_pc_n;
  logic [63:0]   disc_addr, disc_addr_n;
  logic [63:0]   mem_pc   [BUF_DEPTH];
  logic [31:0]   mem_inst [BUF_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_after;
  logic          push, pop, flush;

  always_comb begin
    state_n     = state;
    fetch_pc_n  = fetch_pc;
    disc_addr_n = disc_addr;
    push        = 1'b0;
    flush       = 1'b0;
    imem_req    = 1'b0;
    imem_addr   = fetch_pc;
    pop         = !stall_ID && !redirect_en && (count != '0);

    case (state)
      S_IDLE: state_n = S_FETCH;
      S_FETCH: begin
        imem_req = (count < DEPTH_C);
        if (imem_req && imem_ack) begin
          push       = 1'b1;
          fetch_pc_n = fetch_pc + 64'd4;
        end
      end
      S_HOLD: if (count < DEPTH_C) state_n = S_FETCH;
      S_DISCARD: begin
        imem_req  = 1'b1;
        imem_addr = disc_addr;
        if (imem_ack) state_n = S_FETCH;
      end
      default: state_n = S_IDLE;
    endcase

    // Redirect wins over ack-push; an unanswered request becomes a wrong-path one to be drained.
    if (redirect_en) begin
      flush      = 1'b1;
      push       = 1'b0;
      fetch_pc_n = redirect_pc & ~64'h3;
      case (state)
        S_FETCH: begin
          if (imem_req && !imem_ack) begin
            state_n     = S_DISCARD;
            disc_addr_n = fetch_pc;
          end else begin
            state_n = S_FETCH;
          end
        end
        S_DISCARD: state_n = imem_ack ? S_FETCH : S_DISCARD;
        default:   state_n = S_FETCH;
      endcase
    end

    count_after = count + CW'(push) - CW'(pop);
    if (!redirect_en && state == S_FETCH && push && count_after == DEPTH_C)
      state_n = S_HOLD;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      fetch_pc  <= RESET_PC;
      disc_addr <= RESET_PC;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state     <= state_n;
      fetch_pc  <= fetch_pc_n;
      disc_addr <= disc_addr_n;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        count <= count_after;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fetch_pc;
      mem_inst[wr_ptr] <= imem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_IF <= NOP_INST;
      pc_IF          <= 64'h0;
      valid_IF       <= 1'b0;
    end else if (redirect_en) begin
      instruction_IF <= NOP_INST;
      valid_IF       <= 1'b0;
    end else if (!stall_ID) begin
      if (pop) begin
        instruction_IF <= mem_inst[rd_ptr];
        pc_IF          <= mem_pc[rd_ptr];
        valid_IF       <= 1'b1;
      end else begin
        instruction_IF <= NOP_INST;
        valid_IF       <= 1'b0;
      end
    end
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt  <= 32'h0;
      perf_bubble_cnt <= 32'h0;
    end else begin
      if (push) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (!stall_ID && !pop) perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_if_fetch_stage.sv
// tb/tb_pipeline_if_fetch_stage.sv - directed self-checking bench for pipeline_if_fetch_stage
module tb_pipeline_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall_ID = 1'b0;
  logic        redirect_en = 1'b0;
  logic [63:0] redirect_pc = 64'h0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic [31:0] instruction_IF;
  logic [63:0] pc_IF;
  logic        valid_IF;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_bubble_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipeline_if_fetch_stage dut (
    .clk(clk), .reset(reset), .stall_ID(stall_ID), .redirect_en(redirect_en),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .instruction_IF(instruction_IF),
    .pc_IF(pc_IF), .valid_IF(valid_IF)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_bubble_cnt(perf_bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    imem_rdata = imem_addr[31:0];
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; stall_ID = 1'b0; redirect_en = 1'b0; imem_ack = 1'b0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, 64'(imem_req), 64'h0);
    check({tag, "_addr"}, imem_addr, 64'h0);
    check({tag, "_inst"}, 64'(instruction_IF), 64'h13);
    check({tag, "_pc"}, pc_IF, 64'h0);
    check({tag, "_valid"}, 64'(valid_IF), 64'h0);
  endtask

  initial begin
    logic [63:0] exp_pc;
    int seen;
    bit found;

    // 1: streaming fetch from reset
    do_reset();
    check_reset_outputs("rst");
    imem_ack = 1'b1;
    step();
    check("t1_e1_valid", 64'(valid_IF), 64'h0);
    step();
    check("t1_e2_valid", 64'(valid_IF), 64'h0);
    for (int k = 0; k < 6; k++) begin
      step();
      check("t1_valid", 64'(valid_IF), 64'h1);
      check("t1_pc", pc_IF, 64'(4 * k));
      check("t1_inst", 64'(instruction_IF), 64'(4 * k));
    end

    // 2: stall with FIFO filling, then drain in order
    stall_ID = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      check("t2_hold_pc", pc_IF, 64'h14);
      check("t2_hold_valid", 64'(valid_IF), 64'h1);
      check("t2_req_low", 64'(imem_req), 64'h0);
    end
    stall_ID = 1'b0;
    exp_pc = 64'h18;
    seen = 0;
    for (int k = 0; k < 20 && seen < 4; k++) begin
      step();
      if (valid_IF) begin
        check("t2_seq_pc", pc_IF, exp_pc);
        check("t2_seq_inst", 64'(instruction_IF), 64'(exp_pc[31:0]));
        exp_pc = exp_pc + 64'd4;
        seen++;
      end
    end
    check("t2_drained", 64'(seen), 64'd4);

    // 3: redirect while request at 0x20 is outstanding
    do_reset();
    step();
    redirect_en = 1'b1; redirect_pc = 64'h20;
    step();
    check("t3_disc_addr0", imem_addr, 64'h0);
    redirect_en = 1'b0; imem_ack = 1'b1;
    step();
    imem_ack = 1'b0;
    check("t3_req_20", 64'(imem_req), 64'h1);
    check("t3_addr_20", imem_addr, 64'h20);
    redirect_en = 1'b1; redirect_pc = 64'h1003;
    step();
    redirect_en = 1'b0;
    check("t3_valid_after_redir", 64'(valid_IF), 64'h0);
    check("t3_addr_held", imem_addr, 64'h20);
    step(); step();
    check("t3_addr_held2", imem_addr, 64'h20);
    imem_ack = 1'b1;
    step();
    check("t3_addr_target", imem_addr, 64'h1000);
    check("t3_no_20", 64'(valid_IF), 64'h0);
    step();
    check("t3_no_20b", 64'(valid_IF), 64'h0);
    step();
    check("t3_pc_target", pc_IF, 64'h1000);
    check("t3_valid_target", 64'(valid_IF), 64'h1);
    check("t3_inst_target", 64'(instruction_IF), 64'h1000);

    // 4: redirect on the same edge as the ack for 0x40
    do_reset();
    imem_ack = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      if (imem_addr == 64'h40 && imem_req) found = 1'b1;
      else step();
    end
    check("t4_reached_40", 64'(found), 64'h1);
    redirect_en = 1'b1; redirect_pc = 64'h200;
    step();
    redirect_en = 1'b0;
    check("t4_valid_drop", 64'(valid_IF), 64'h0);
    check("t4_addr_target", imem_addr, 64'h200);
    check("t4_req", 64'(imem_req), 64'h1);
    step();
    check("t4_bubble", 64'(valid_IF), 64'h0);
    step();
    check("t4_pc_target", pc_IF, 64'h200);
    check("t4_valid_target", 64'(valid_IF), 64'h1);

    // 5: reset while discarding
    imem_ack = 1'b0;
    step();
    redirect_en = 1'b1; redirect_pc = 64'h800;
    step();
    redirect_en = 1'b0;
    check("t5_in_discard", 64'(imem_req), 64'h1);
    reset = 1'b1;
    step();
    check_reset_outputs("t5_rst");
    reset = 1'b0;
    step();
    check("t5_first_addr", imem_addr, 64'h0);
    check("t5_first_req", 64'(imem_req), 64'h1);

`ifdef IF_PERF_CNT_EN
    // 6: 10 pushes, 2 dropped acks, 4 bubbles
    do_reset();
    check("t6_rst_fetch", 64'(perf_fetch_cnt), 64'h0);
    check("t6_rst_bubble", 64'(perf_bubble_cnt), 64'h0);
    imem_ack = 1'b1;
    for (int k = 0; k < 11; k++) step();
    imem_ack = 1'b0; stall_ID = 1'b1;
    step();
    redirect_en = 1'b1; redirect_pc = 64'h100;
    step();
    redirect_en = 1'b0; imem_ack = 1'b1;
    step();
    redirect_en = 1'b1; redirect_pc = 64'h300;
    step();
    redirect_en = 1'b0; imem_ack = 1'b0; stall_ID = 1'b0;
    step(); step();
    stall_ID = 1'b1;
    step();
    check("t6_fetch_cnt", 64'(perf_fetch_cnt), 64'd10);
    check("t6_bubble_cnt", 64'(perf_bubble_cnt), 64'd4);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
